mux_sel_rr_arbiter: RTL and testbench
=====================================

Name: mux_sel_rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 dataflow mux and drives its s1/s0 select lines.
- Four requesters compete for the shared mux output. The block grants one channel at a time and presents that channel's binary index on sel_s1/sel_s0.
- It supports hold-while-requesting transactions with an optional maximum hold time, so that no channel is starved.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per channel while others wait; 0 = unlimited.
- CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-channel request; req[i] high = channel i wants the mux.
- grant  output  4  one-hot grant, registered; all zero when idle.
- sel_s1  output  1  select MSB to mux (s1), registered.
- sel_s0  output  1  select LSB to mux (s0), registered.
- busy  output  1  high while any grant is active.

Behaviour:
- Reset (async, rst_n=0):
  - grant=4'b0000, sel_s1=0, sel_s0=0, busy=0.
  - State=IDLE, hold_cnt=0, last_ptr=3, so channel 0 has top priority after reset.
  - Reset asserted mid-grant clears all state immediately, with no wait for a clock edge.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If req != 0, select the winner as the first requesting channel scanning (last_ptr+1) mod 4 upward with wrap-around.
  - On the next edge: go to GRANT, grant=onehot(winner), {sel_s1,sel_s0}=winner, busy=1, last_ptr=winner, hold_cnt=0.
  - Latency from req assertion to grant is 1 clock.
- GRANT, current channel g:
  - Keep: req[g]=1 and (MAX_HOLD=0 or hold_cnt < MAX_HOLD-1) -> grant unchanged, hold_cnt increments.
  - Release: req[g]=0 ->
    - If another req is pending, grant the next round-robin winner at the next edge. There is no idle bubble, and hold_cnt restarts at 0.
    - Otherwise return to IDLE: grant=0, busy=0.
  - Expiry: req[g]=1 and hold_cnt = MAX_HOLD-1 ->
    - If another channel requests, force rotation to the next round-robin winner, which excludes g.
    - If no other channel requests, keep g and reset hold_cnt to 0.
- Select lines:
  - sel_s1/sel_s0 always equal the binary index of the most recent grant.
  - They hold their last value in IDLE, so the mux output stays stable.
  - They change only on the same edge as grant.
- Invariants:
  - grant is one-hot or zero; never more than one bit set.
  - busy == |grant.
- Simultaneous events:
  - Multiple requests arriving in the same cycle are resolved purely by the rotating priority from last_ptr.
  - A req drop and a hold expiry in the same cycle are treated as a release.
- hold_cnt saturates and never wraps; CNT_W is sized so it cannot overflow.

Decomposition:
- Shared package mux_sel_pkg holds:
  - NUM_CH=4 and SEL_W=2.
  - State typedef {IDLE, GRANT}.
  - Function rr_pick(req, last_ptr), returning the winner index and a valid flag.
- Natural sub-module: rr_priority_pick, a combinational rotating priority encoder used by both the IDLE and GRANT transitions.
- Top level holds the FSM, hold counter and output registers.

Test Plan:
- Reset, then req=4'b0001 -> one clock later grant=0001, sel_s1=0, sel_s0=0, busy=1. Drop req -> next clock grant=0000, busy=0, selects stay 00.
- req=4'b1111 held, MAX_HOLD=8 -> grant cycles 0001,0010,0100,1000,0001 with 8 cycles each; sel sequence 00,01,10,11,00.
- Only req[2]=1 held for 20 cycles -> grant stays 0100 continuously (no forced drop), sel=10.
- Grant on ch1; at cycle 3 drop req[1] while req[3]=1 -> next edge grant=1000, sel=11, busy never goes low.
- Grant on ch3; then req=4'b0011 -> next winner ch0 (wrap-around); grant=0001.
- Assert rst_n=0 asynchronously mid-grant on ch2 -> grant=0, sel=00, busy=0 before the next clock edge. After release with req=4'b0100 -> grant=0100 one clock later.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared types and the rotating-priority helper for the 4:1 mux select arbiter.
// The arbiter FSM, the priority encoder sub-module and the top all import this package.
package mux_sel_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // The first requester found scanning upward from last_ptr+1 with wrap-around wins.
  // The scan runs from the farthest offset down to the nearest, so the nearest requester writes last.
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] req,
                                    input logic [SEL_W-1:0]  last_ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res.valid = 1'b0;
    res.idx   = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = last_ptr + SEL_W'(k);
      if (req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_sel_rr_arbiter_pick.sv
// Combinational rotating priority encoder.
// It returns the winning channel index, a valid flag and the one-hot form of the winner.
module rr_priority_pick
  import mux_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_ptr,
  output logic              valid,
  output logic [SEL_W-1:0]  idx,
  output logic [NUM_CH-1:0] onehot
);

  pick_t pick;

  assign pick  = rr_pick(req, last_ptr);
  assign valid = pick.valid;
  assign idx   = pick.idx;

  // When nothing requests, the one-hot output is zero even though idx is 0.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
    assign onehot[gi] = pick.valid && (pick.idx == SEL_W'(gi));
  end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter driving the s1/s0 selects of the downstream 4:1 mux.
// Grants are held while the owner keeps requesting, up to MAX_HOLD cycles whenever other channels are waiting.
module mux_sel_rr_arbiter
  import mux_sel_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic              sel_s1,
  output logic              sel_s0,
  output logic              busy
);

  localparam int              HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_LAST_I);

  state_t            state_reg, state_next;
  logic [SEL_W-1:0]  last_ptr_reg, last_ptr_next;
  logic [CNT_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [NUM_CH-1:0] grant_reg, grant_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;

  logic [NUM_CH-1:0] cand_req;
  logic              pick_valid;
  logic [SEL_W-1:0]  pick_idx;
  logic [NUM_CH-1:0] pick_onehot;
  logic              owner_req;
  logic              hold_expired;

  // The current owner is masked out, so the encoder yields "next other winner" in GRANT and the plain winner in IDLE.
  assign cand_req     = req & ~grant_reg;
  assign owner_req    = |(req & grant_reg);
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);

  rr_priority_pick u_pick (
    .req      (cand_req),
    .last_ptr (last_ptr_reg),
    .valid    (pick_valid),
    .idx      (pick_idx),
    .onehot   (pick_onehot)
  );

  always_comb begin
    state_next    = state_reg;
    last_ptr_next = last_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    sel_next      = sel_reg;

    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next    = GRANT;
          grant_next    = pick_onehot;
          sel_next      = pick_idx;
          last_ptr_next = pick_idx;
          hold_cnt_next = '0;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // A release takes precedence over an expiry landing in the same cycle.
          hold_cnt_next = '0;
          if (pick_valid) begin
            grant_next    = pick_onehot;
            sel_next      = pick_idx;
            last_ptr_next = pick_idx;
          end else begin
            state_next = IDLE;
            grant_next = '0;
          end
        end else if (hold_expired) begin
          hold_cnt_next = '0;
          if (pick_valid) begin
            grant_next    = pick_onehot;
            sel_next      = pick_idx;
            last_ptr_next = pick_idx;
          end
        end else if (hold_cnt_reg != '1) begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // last_ptr resets to the top channel so that channel 0 is scanned first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_ptr_reg <= SEL_W'(NUM_CH - 1);
      hold_cnt_reg <= '0;
      grant_reg    <= '0;
      sel_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      last_ptr_reg <= last_ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      sel_reg      <= sel_next;
    end
  end

  assign grant  = grant_reg;
  assign sel_s1 = sel_reg[1];
  assign sel_s0 = sel_reg[0];
  assign busy   = |grant_reg;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Scoreboard bench for mux_sel_rr_arbiter: stimulus pushes hand-computed expectations,
// and a monitor pops and compares them one clock later.
module tb_mux_sel_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       sel_s1;
  logic       sel_s0;
  logic       busy;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  mux_sel_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .grant  (grant),
    .sel_s1 (sel_s1),
    .sel_s0 (sel_s0),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string nm, input logic [3:0] r, input logic [3:0] g,
                         input logic [1:0] s, input logic b);
    n_checks++;
    n_txn++;
    if (grant !== g || {sel_s1, sel_s0} !== s || busy !== b) begin
      n_fail++;
      $display("FAIL %s: req=%b got grant=%b sel=%b%b busy=%b, expected grant=%b sel=%b busy=%b",
               nm, r, grant, sel_s1, sel_s0, busy, g, s, b);
    end else begin
      $display("txn %0d %s: req=%b grant=%b sel=%b%b busy=%b ok",
               n_txn, nm, r, grant, sel_s1, sel_s0, busy);
    end
  endtask

  // Drive req on the falling edge; the DUT answers at the following rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                      input string nm);
    exp_t e;
    @(negedge clk);
    req    = r;
    e.req  = r;
    e.grant = g;
    e.sel  = s;
    e.busy = (g != 4'b0000);
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e.name, e.req, e.grant, e.sel, e.busy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] oh;
    exp_t       e;
    rst_n = 1'b0;
    req   = 4'b0000;
    #12;
    compare("reset_state", req, 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester: grant one clock later, then release back to idle with selects held.
    step(4'b0001, 4'b0001, 2'b00, "ch0_grant");
    step(4'b0000, 4'b0000, 2'b00, "ch0_release");
    step(4'b0000, 4'b0000, 2'b00, "idle_hold_sel");

    // All four requesting from fresh reset: 8-cycle slices rotating 0,1,2,3,0.
    pulse_reset();
    for (int i = 0; i < 40; i++) begin
      oh = 4'b0001 << ((i / 8) % 4);
      step(4'b1111, oh, 2'((i / 8) % 4), $sformatf("rr_all_%0d", i));
    end
    step(4'b0000, 4'b0000, 2'b00, "rr_all_drop");

    // Lone requester on ch2 is never forced off by expiry.
    for (int i = 0; i < 20; i++)
      step(4'b0100, 4'b0100, 2'b10, $sformatf("ch2_alone_%0d", i));
    step(4'b0000, 4'b0000, 2'b10, "ch2_drop");
    step(4'b0000, 4'b0000, 2'b10, "ch2_idle_sel");

    // Release of ch1 with ch3 pending hands over with no idle bubble.
    step(4'b0010, 4'b0010, 2'b01, "ch1_grant");
    step(4'b1010, 4'b0010, 2'b01, "ch1_keep");
    step(4'b1000, 4'b1000, 2'b11, "ch1_to_ch3");
    step(4'b1000, 4'b1000, 2'b11, "ch3_keep");

    // From ch3, ch0 wins over ch1 by wrap-around.
    step(4'b0011, 4'b0001, 2'b00, "ch3_wrap_ch0");
    step(4'b0011, 4'b0001, 2'b00, "ch0_keep");
    step(4'b0010, 4'b0010, 2'b01, "ch0_to_ch1");
    step(4'b0000, 4'b0000, 2'b01, "ch1_release");

    // Drop coinciding with expiry is a release: back to idle.
    for (int i = 0; i < 8; i++)
      step(4'b0100, 4'b0100, 2'b10, $sformatf("ch2_hold_%0d", i));
    step(4'b0000, 4'b0000, 2'b10, "drop_at_expiry");

    // Simultaneous arrivals resolved from last_ptr=2: ch3 before ch0.
    step(4'b1001, 4'b1000, 2'b11, "multi_from_ch2");
    step(4'b0000, 4'b0000, 2'b11, "multi_release");

    // Asynchronous reset mid-grant on ch2.
    step(4'b0100, 4'b0100, 2'b10, "ch2_pre_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compare("async_reset_mid_grant", req, 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0100;
    e.req   = 4'b0100;
    e.grant = 4'b0100;
    e.sel   = 2'b10;
    e.busy  = 1'b1;
    e.name  = "post_reset_ch2";
    exp_q.push_back(e);
    step(4'b0000, 4'b0000, 2'b10, "post_reset_release");

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
